alu_arbiter: RTL and testbench

Two-requester front end for the shared 8-bit ALU. It accepts operations (A, B, OP) from two independent clients over valid/ready handshakes and picks a winner round-robin. It drives the winner's registered operands into the ALU, captures Y and the C/V/N/Z flags, and returns them to the client on a tagged response channel with backpressure. It sits between the instruction-side and test/debug-side issuers and the ALU instance.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 22 ++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU arbiter
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_OP_W   = 3;

    // Bit positions inside the packed {C,V,N,Z} response flags
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    // Pack individual ALU flags into the response flag nibble
    function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                              input logic n, input logic z);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker, purely combinational
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On a tie the requester that did not win last time is chosen;
    // a lone requester always wins so it can never be starved.
    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-client round-robin front end for the shared ALU
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              alu_n,
    input  logic              alu_z,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_y,
    output logic [3:0]        rsp_flags
);

    arb_state_t        state_q, state_d;
    logic              last_grant_q;
    logic              cur_id_q;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic [OP_W-1:0]   opc_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_y_q;
    logic [3:0]        rsp_flags_q;

    logic [1:0]        grant;
    logic              accept;
    logic              win_id;

    rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Ready only in IDLE and only to the picked requester; rsp_ready never feeds in
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset && state_q == IDLE) begin
            req0_ready = grant[0];
            req1_ready = grant[1];
        end
        accept = req0_ready | req1_ready;
        win_id = req1_ready;
    end

    // Next-state logic: accept -> issue one cycle -> hold response until taken
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_valid_q && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operand register, grant history and response register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cur_id_q     <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_y_q      <= '0;
            rsp_flags_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opa_q        <= win_id ? req1_a  : req0_a;
                opb_q        <= win_id ? req1_b  : req0_b;
                opc_q        <= win_id ? req1_op : req0_op;
                cur_id_q     <= win_id;
                last_grant_q <= win_id;
            end
            if (state_q == ISSUE) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= cur_id_q;
                rsp_y_q     <= alu_y;
                rsp_flags_q <= pack_flags(alu_c, alu_v, alu_n, alu_z);
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign alu_a     = opa_q;
    assign alu_b     = opb_q;
    assign alu_op    = opc_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_op;
    logic       alu_c, alu_v, alu_n, alu_z;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_y;
    logic [3:0] rsp_flags;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(8), .OP_W(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags)
    );

    // Reference ALU: 0 add, 1 sub (C = borrow), 2 and, 3 or, 4 xor, else pass A
    always_comb begin
        logic [8:0] wide;
        wide  = 9'd0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_op)
            3'd0: begin
                wide  = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c = wide[8];
                alu_v = (alu_a[7] == alu_b[7]) && (wide[7] != alu_a[7]);
            end
            3'd1: begin
                wide  = {1'b0, alu_a} - {1'b0, alu_b};
                alu_c = alu_a < alu_b;
                alu_v = (alu_a[7] != alu_b[7]) && (wide[7] != alu_a[7]);
            end
            3'd2:    wide = {1'b0, alu_a & alu_b};
            3'd3:    wide = {1'b0, alu_a | alu_b};
            3'd4:    wide = {1'b0, alu_a ^ alu_b};
            default: wide = {1'b0, alu_a};
        endcase
        alu_y = wide[7:0];
        alu_n = wide[7];
        alu_z = (wide[7:0] == 8'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_y [4];
        logic       exp_id [4];
        exp_y  = '{8'h11, 8'h1E, 8'h12, 8'h1F};
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};

        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00; req0_op = 3'd0;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 3'd0;

        // Reset state
        #1;
        check("rst_req0_ready", req0_ready, 0);
        tick();
        check("rst_req0_ready_edge", req0_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        req0_valid = 1'b0;
        reset = 1'b0;

        // Single request: 5 + 3
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 3'd0;
        rsp_ready = 1'b1;
        #1;
        check("single_req0_ready", req0_ready, 1);
        check("single_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("single_alu_a", alu_a, 8'h05);
        check("single_alu_b", alu_b, 8'h03);
        check("single_alu_op", alu_op, 0);
        check("single_issue_rsp_valid", rsp_valid, 0);
        check("single_issue_ready", req0_ready, 0);
        tick();
        check("single_rsp_valid", rsp_valid, 1);
        check("single_rsp_id", rsp_id, 0);
        check("single_rsp_y", rsp_y, 8'h08);
        check("single_rsp_flags", rsp_flags, 4'b0000);
        tick();
        check("single_rsp_drop", rsp_valid, 0);

        // Flag capture: FF + 01 -> 00 with C and Z
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01; req1_op = 3'd0;
        #1;
        check("flag_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("flag_rsp_y", rsp_y, 8'h00);
        check("flag_rsp_flags", rsp_flags, 4'b1001);
        check("flag_rsp_id", rsp_id, 1);
        tick();

        // Contention: both valid continuously after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h01; req0_op = 3'd0;
        req1_valid = 1'b1; req1_a = 8'h20; req1_b = 8'h02; req1_op = 3'd1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cont_req0_ready", req0_ready, !exp_id[k]);
            check("cont_req1_ready", req1_ready, exp_id[k]);
            tick();
            if (exp_id[k]) req1_a = req1_a + 8'd1;
            else           req0_a = req0_a + 8'd1;
            #1;
            check("cont_issue_ready", {req1_ready, req0_ready}, 0);
            tick();
            check("cont_rsp_valid", rsp_valid, 1);
            check("cont_rsp_id", rsp_id, exp_id[k]);
            check("cont_rsp_y", rsp_y, exp_y[k]);
            check("cont_resp_ready", {req1_ready, req0_ready}, 0);
            tick();
        end

        // Backpressure: 7F + 01 -> 80 with V and N, req1 left pending
        req0_a = 8'h7F; req0_b = 8'h01; req0_op = 3'd0;
        rsp_ready = 1'b0;
        #1;
        check("bp_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_y", rsp_y, 8'h80);
        check("bp_rsp_flags", rsp_flags, 4'b0110);
        check("bp_rsp_id", rsp_id, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_y", rsp_y, 8'h80);
            check("bp_hold_flags", rsp_flags, 4'b0110);
            check("bp_hold_id", rsp_id, 0);
            check("bp_hold_ready", {req1_ready, req0_ready}, 0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_no_lookahead", req1_ready, 0);
        tick();
        check("bp_rsp_taken", rsp_valid, 0);
        check("bp_next_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("bp_next_rsp_id", rsp_id, 1);
        check("bp_next_rsp_y", rsp_y, 8'h20);
        tick();

        // Reset during ISSUE
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h11; req1_op = 3'd2;
        #1;
        check("rst_issue_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_issue_rsp_valid", rsp_valid, 0);
        check("rst_issue_alu_a", alu_a, 0);
        check("rst_issue_alu_b", alu_b, 0);
        check("rst_issue_alu_op", alu_op, 0);
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 3'd0;
        req1_valid = 1'b1; req1_a = 8'h44; req1_b = 8'h44; req1_op = 3'd4;
        #1;
        check("rst_issue_tie_req0", req0_ready, 1);
        check("rst_issue_tie_req1", req1_ready, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        check("rst_resp_pre_valid", rsp_valid, 1);
        check("rst_resp_pre_y", rsp_y, 8'h03);

        // Reset during RESP
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_resp_valid", rsp_valid, 0);
        check("rst_resp_y", rsp_y, 0);
        check("rst_resp_flags", rsp_flags, 0);
        check("rst_resp_alu_a", alu_a, 0);
        rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_resp_no_stale", rsp_valid, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_resp_tie_req0", req0_ready, 1);
        check("rst_resp_tie_req1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Lone req1 back-to-back right after reset (last_grant = 1)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req1_a = 8'(i * 16); req1_b = 8'h01; req1_op = 3'd0;
            #1;
            check("solo_req1_ready", req1_ready, 1);
            tick();
            check("solo_alu_a", alu_a, 8'(i * 16));
            tick();
            check("solo_rsp_id", rsp_id, 1);
            check("solo_rsp_y", rsp_y, 8'(i * 16 + 1));
            tick();
        end
        req1_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
